// File: rtl/arb_req_queue.sv
// Two-source request queue in front of a 2-requester fixed-priority arbiter.
// Optional occupancy/drop reporting is enabled with `define ARB_REQ_QUEUE_LEVEL_EN.
module arb_req_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    output logic              req_0,
    output logic              req_1,
    input  logic              gnt_0,
    input  logic              gnt_1,
    output logic              out_valid,
    output logic              out_src,
    output logic [DATA_W-1:0] out_data
`ifdef ARB_REQ_QUEUE_LEVEL_EN
    ,
    output logic [PTR_W:0]    level0,
    output logic [PTR_W:0]    level1,
    output logic              push_drop
`endif
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [2];
    logic [PTR_W-1:0]  rd_ptr [2];
    logic [PTR_W:0]    count [2];
    logic [DATA_W-1:0] in_data [2];
    logic [1:0]        in_valid;
    logic [1:0]        ready;
    logic [1:0]        req;
    logic [1:0]        push;
    logic [1:0]        pop;

    assign in_valid   = {in1_valid, in0_valid};
    assign in_data[0] = in0_data;
    assign in_data[1] = in1_data;

    // Ready and request come only from the registered counts, never from this cycle's pop.
    assign ready = {count[1] != FULL, count[0] != FULL};
    assign req   = {count[1] != '0, count[0] != '0};
    assign push  = in_valid & ready;

    assign in0_ready = ready[0];
    assign in1_ready = ready[1];
    assign req_0     = req[0];
    assign req_1     = req[1];

    // NOTE: every variable in an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        pop = '0;
        if (gnt_0 && req[0]) begin
            pop[0] = 1'b1;
        end else if (gnt_1 && req[1]) begin
            pop[1] = 1'b1;
        end
    end

    // NOTE: the payload array has no reset; pointers and counts define which entries are live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + (PTR_W+1)'(1);
                    2'b01:   count[i] <= count[i] - (PTR_W+1)'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_src   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= |pop;
            if (pop[0]) begin
                out_src  <= 1'b0;
                out_data <= mem[0][rd_ptr[0]];
            end else if (pop[1]) begin
                out_src  <= 1'b1;
                out_data <= mem[1][rd_ptr[1]];
            end
        end
    end

`ifdef ARB_REQ_QUEUE_LEVEL_EN
    assign level0 = count[0];
    assign level1 = count[1];

    // Sticky: any refused push attempt on either source is remembered until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            push_drop <= 1'b0;
        end else if (|(in_valid & ~ready)) begin
            push_drop <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Scoreboard bench for arb_req_queue: queue-based reference model, attached arbiter model,
// directed scenarios plus a randomized phase.
module tb_arb_req_queue;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = $clog2(DEPTH);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in0_valid = 1'b0;
    logic              in1_valid = 1'b0;
    logic [DATA_W-1:0] in0_data = '0;
    logic [DATA_W-1:0] in1_data = '0;
    logic              in0_ready, in1_ready;
    logic              req_0, req_1;
    logic              gnt_0, gnt_1;
    logic              out_valid, out_src;
    logic [DATA_W-1:0] out_data;
`ifdef ARB_REQ_QUEUE_LEVEL_EN
    logic [PTR_W:0]    level0, level1;
    logic              push_drop;
`endif

    arb_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .req_0     (req_0),
        .req_1     (req_1),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .out_valid (out_valid),
        .out_src   (out_src),
        .out_data  (out_data)
`ifdef ARB_REQ_QUEUE_LEVEL_EN
        ,
        .level0    (level0),
        .level1    (level1),
        .push_drop (push_drop)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arbiter environment: registered fixed-priority grant, or a forced grant pattern.
    logic       arb_en = 1'b0;
    logic [1:0] force_gnt = 2'b00;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_0 <= 1'b0;
            gnt_1 <= 1'b0;
        end else if (arb_en) begin
            gnt_0 <= req_0;
            gnt_1 <= req_1 & ~req_0;
        end else begin
            gnt_0 <= force_gnt[0];
            gnt_1 <= force_gnt[1];
        end
    end

    // Reference model: one queue per source, a scoreboard of expected strobes.
    logic [DATA_W-1:0] mq0[$];
    logic [DATA_W-1:0] mq1[$];
    logic [DATA_W:0]   sb[$];
    logic [DATA_W:0]   log_q[$];
    bit                drop_exp = 1'b0;
    bit                m_p0, m_p1, m_full0, m_full1;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq0.delete();
            mq1.delete();
            sb.delete();
            drop_exp = 1'b0;
        end else begin
            m_full0 = (mq0.size() == DEPTH);
            m_full1 = (mq1.size() == DEPTH);
            m_p0 = gnt_0 && (mq0.size() != 0);
            m_p1 = gnt_1 && (mq1.size() != 0) && !m_p0;
            if (m_p0) sb.push_back({1'b0, mq0.pop_front()});
            if (m_p1) sb.push_back({1'b1, mq1.pop_front()});
            if (in0_valid) begin
                if (m_full0) drop_exp = 1'b1;
                else         mq0.push_back(in0_data);
            end
            if (in1_valid) begin
                if (m_full1) drop_exp = 1'b1;
                else         mq1.push_back(in1_data);
            end
        end
    end

    // Monitor: compares every strobe and the status outputs against the model.
    logic [DATA_W:0] exp_e;
    always @(negedge clock) begin
        if (!reset) begin
            check("out_valid", out_valid, sb.size() != 0);
            if (out_valid && sb.size() != 0) begin
                exp_e = sb.pop_front();
                check("out_entry", {out_src, out_data}, exp_e);
                log_q.push_back({out_src, out_data});
            end
            check("req_0", req_0, mq0.size() != 0);
            check("req_1", req_1, mq1.size() != 0);
            check("in0_ready", in0_ready, mq0.size() != DEPTH);
            check("in1_ready", in1_ready, mq1.size() != DEPTH);
`ifdef ARB_REQ_QUEUE_LEVEL_EN
            check("level0", level0, mq0.size());
            check("level1", level1, mq1.size());
            check("push_drop", push_drop, drop_exp);
`endif
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (!(mq0.size() == 0 && mq1.size() == 0 && sb.size() == 0 && !out_valid) && k < 80) begin
            tick();
            k++;
        end
        n_tests++;
        if (k >= 80) begin
            n_fail++;
            $display("FAIL %s: drain timeout, q0=%0d q1=%0d sb=%0d required all empty",
                     name, mq0.size(), mq1.size(), sb.size());
        end
        tick();
    endtask

    task automatic push_one(input bit src, input logic [DATA_W-1:0] d);
        if (src) begin in1_valid = 1'b1; in1_data = d; end
        else     begin in0_valid = 1'b1; in0_data = d; end
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset then idle.
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_req_0", req_0, 0);
        check("rst_req_1", req_1, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_src", out_src, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in0_ready", in0_ready, 1);
        check("rst_in1_ready", in1_ready, 1);
        repeat (3) tick();

        // Single push latency: req at T+1, strobe at T+3, exactly one strobe.
        arb_en = 1'b1;
        log_q.delete();
        in0_valid = 1'b1; in0_data = 8'hA1;
        tick();
        in0_valid = 1'b0;
        check("lat_req_t1", req_0, 1);
        tick();
        check("lat_nostrobe_t2", out_valid, 0);
        tick();
        check("lat_strobe_t3", out_valid, 1);
        check("lat_data", {out_src, out_data}, {1'b0, 8'hA1});
        tick();
        check("lat_single", out_valid, 0);
        wait_drain("latency");

        // Fill source 1 with no grant; fifth push refused.
        arb_en = 1'b0; force_gnt = 2'b00;
        for (int i = 0; i < 4; i++) push_one(1'b1, 8'h10 + 8'(i));
        check("fill_ready0", in1_ready, 0);
        push_one(1'b1, 8'h14);
        check("fill_req1", req_1, 1);
`ifdef ARB_REQ_QUEUE_LEVEL_EN
        check("fill_drop", push_drop, 1);
        check("fill_level1", level1, 4);
`endif
        log_q.delete();
        arb_en = 1'b1;
        wait_drain("fill");
        check("fill_count", log_q.size(), 4);
        if (log_q.size() == 4) check("fill_last", log_q[3], {1'b1, 8'h13});

        // Source 1 streaming, source 0 interrupts.
        arb_en = 1'b0; force_gnt = 2'b00;
        for (int i = 0; i < 4; i++) push_one(1'b1, 8'h20 + 8'(i));
        log_q.delete();
        arb_en = 1'b1;
        k = 0;
        while (!out_valid && k < 20) begin tick(); k++; end
        check("stream_started", out_valid, 1);
        push_one(1'b0, 8'h30);
        wait_drain("stream");
        check("stream_count", log_q.size(), 5);
        if (log_q.size() == 5) begin
            check("stream_e0", log_q[0], {1'b1, 8'h20});
            check("stream_e1", log_q[1], {1'b1, 8'h21});
            check("stream_e2", log_q[2], {1'b1, 8'h22});
            check("stream_pre", log_q[3], {1'b0, 8'h30});
            check("stream_resume", log_q[4], {1'b1, 8'h23});
        end

        // Two entries per FIFO, both granted in turn.
        arb_en = 1'b0; force_gnt = 2'b00;
        in0_valid = 1'b1; in0_data = 8'h40; in1_valid = 1'b1; in1_data = 8'h48; tick();
        in0_data = 8'h41; in1_data = 8'h49; tick();
        in0_valid = 1'b0; in1_valid = 1'b0;
        log_q.delete();
        arb_en = 1'b1;
        wait_drain("both");
        check("both_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("both_src_seq", {log_q[0][DATA_W], log_q[1][DATA_W], log_q[2][DATA_W], log_q[3][DATA_W]}, 4'b0011);
            check("both_data3", log_q[3][DATA_W-1:0], 8'h49);
        end

        // Illegal double grant: only FIFO 0 pops.
        arb_en = 1'b0; force_gnt = 2'b00;
        in0_valid = 1'b1; in0_data = 8'h60; in1_valid = 1'b1; in1_data = 8'h68; tick();
        in0_valid = 1'b0; in1_data = 8'h69; tick();
        in1_valid = 1'b0;
        log_q.delete();
        force_gnt = 2'b11; tick();
        force_gnt = 2'b00; tick();
        tick();
        check("dbl_count", log_q.size(), 1);
        if (log_q.size() == 1) check("dbl_entry", log_q[0], {1'b0, 8'h60});
        check("dbl_req1", req_1, 1);
`ifdef ARB_REQ_QUEUE_LEVEL_EN
        check("dbl_level1", level1, 2);
`endif
        arb_en = 1'b1;
        wait_drain("dbl");

        // Reset mid-stream with 3 entries queued.
        arb_en = 1'b0; force_gnt = 2'b00;
        for (int i = 0; i < 3; i++) push_one(1'b0, 8'h50 + 8'(i));
        arb_en = 1'b1;
        k = 0;
        while (!out_valid && k < 20) begin tick(); k++; end
        check("rst_mid_strobe", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_req0", req_0, 0);
        check("rst_mid_ready0", in0_ready, 1);
`ifdef ARB_REQ_QUEUE_LEVEL_EN
        check("rst_mid_level0", level0, 0);
`endif
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // Randomized traffic with the arbiter attached or random forced grants.
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) arb_en = ($urandom_range(0, 3) != 0);
            force_gnt = 2'($urandom);
            in0_valid = ($urandom_range(0, 2) == 0);
            in1_valid = ($urandom_range(0, 1) == 0);
            in0_data  = 8'($urandom);
            in1_data  = 8'($urandom);
            tick();
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        arb_en = 1'b1;
        wait_drain("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
